// File: rtl/note_grid_recorder.sv
// Samples note codes once per rhythmic slot, packs each measure into a word and stores it in a
// dual-port measure memory with a registered renderer read port. Optional count-in: COUNT_IN_EN.
//
// state    | meaning
// IDLE     | waiting for a record_in rising edge; tempo latched on that edge
// CLEAR    | zeroing one memory address per cycle
// COUNT_IN | one measure of metronome only, nothing sampled (COUNT_IN_EN builds)
// RECORD   | sampling note_in every tps clocks, writing full/partial measures
// DONE     | memory full, waiting for record_in to drop
module note_grid_recorder #(
    parameter int NOTE_W            = 6,
    parameter int SLOTS_PER_MEASURE = 8,
    parameter int SLOTS_PER_BEAT    = 2,
    parameter int MEASURES          = 20,
    parameter int TICK_W            = 26,
    parameter int MET_PULSE         = 200000
) (
    input  logic                                  pixel_clk_in,
    input  logic                                  rst_n_in,
    input  logic                                  record_in,
    input  logic [TICK_W-1:0]                     ticks_per_slot_in,
    input  logic [NOTE_W-1:0]                     note_in,
    input  logic [$clog2(MEASURES)-1:0]           rd_addr_in,
    output logic [NOTE_W*SLOTS_PER_MEASURE-1:0]   rd_data_out,
    output logic                                  metronome_out,
    output logic                                  recording_out,
    output logic                                  done_out,
    output logic [$clog2(MEASURES)-1:0]           measure_idx_out,
    output logic [$clog2(SLOTS_PER_MEASURE)-1:0]  slot_idx_out
);

    localparam int MA     = $clog2(MEASURES);
    localparam int SA     = $clog2(SLOTS_PER_MEASURE);
    localparam int WORD_W = NOTE_W * SLOTS_PER_MEASURE;

`ifdef COUNT_IN_EN
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_COUNT_IN, S_RECORD, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RECORD, S_DONE} state_t;
`endif

    state_t              state, state_next;
    logic                record_prev;
    logic [TICK_W-1:0]   tps;
    logic [TICK_W-1:0]   tick;
    logic [SA-1:0]       slot;
    logic [MA-1:0]       measure;
    logic [MA-1:0]       clr_addr;
    logic [WORD_W-1:0]   slot_reg;
    logic [WORD_W-1:0]   word_next;
    logic                wr_en;
    logic [MA-1:0]       wr_addr;
    logic [WORD_W-1:0]   wr_data;
    logic                mem_we;
    logic [MA-1:0]       mem_addr;
    logic [WORD_W-1:0]   mem_wdata;
    logic [WORD_W-1:0]   mem [MEASURES];

    logic tick_last, slot_last, meas_last, clr_last, met_on;

    assign tick_last = (tick == tps - TICK_W'(1));
    assign slot_last = (slot == SA'(SLOTS_PER_MEASURE - 1));
    assign meas_last = (measure == MA'(MEASURES - 1));
    assign clr_last  = (clr_addr == MA'(MEASURES - 1));
    // tick never reaches tps, so comparing against MET_PULSE alone gives min(MET_PULSE, tps)
    assign met_on    = ((32'(slot) % SLOTS_PER_BEAT) == 0) && (64'(tick) < 64'(MET_PULSE));

    always_comb begin
        word_next = slot_reg;
        word_next[slot*NOTE_W +: NOTE_W] = note_in;
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= S_IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next      = state;
        recording_out   = 1'b0;
        done_out        = 1'b0;
        metronome_out   = 1'b0;
        measure_idx_out = measure;
        slot_idx_out    = slot;
        case (state)
            S_IDLE: begin
                if (record_in && !record_prev) state_next = S_CLEAR;
            end
            S_CLEAR: begin
                if (!record_in) state_next = S_IDLE;
`ifdef COUNT_IN_EN
                else if (clr_last) state_next = S_COUNT_IN;
`else
                else if (clr_last) state_next = S_RECORD;
`endif
            end
`ifdef COUNT_IN_EN
            S_COUNT_IN: begin
                metronome_out = met_on;
                if (!record_in) state_next = S_IDLE;
                else if (tick_last && slot_last) state_next = S_RECORD;
            end
`endif
            S_RECORD: begin
                recording_out = 1'b1;
                metronome_out = met_on;
                if (!record_in) state_next = S_IDLE;
                else if (tick_last && slot_last && meas_last) state_next = S_DONE;
            end
            S_DONE: begin
                done_out = 1'b1;
                if (!record_in) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            record_prev <= 1'b0;
            tps         <= '0;
            tick        <= '0;
            slot        <= '0;
            measure     <= '0;
            clr_addr    <= '0;
            slot_reg    <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
        end else begin
            record_prev <= record_in;
            wr_en       <= 1'b0;
            case (state)
                S_IDLE: begin
                    tick     <= '0;
                    slot     <= '0;
                    measure  <= '0;
                    clr_addr <= '0;
                    if (record_in && !record_prev)
                        tps <= (ticks_per_slot_in == '0) ? TICK_W'(1) : ticks_per_slot_in;
                end
                S_CLEAR: begin
                    clr_addr <= clr_addr + MA'(1);
                    if (clr_last) begin
                        tick     <= '0;
                        slot     <= '0;
                        measure  <= '0;
                        slot_reg <= '0;
                    end
                end
`ifdef COUNT_IN_EN
                S_COUNT_IN: begin
                    if (tick_last) begin
                        tick <= '0;
                        slot <= slot_last ? '0 : slot + SA'(1);
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
`endif
                S_RECORD: begin
                    if (!record_in) begin
                        // partial measure: unsampled slots are still zero in slot_reg
                        if (slot != '0) begin
                            wr_en   <= 1'b1;
                            wr_addr <= measure;
                            wr_data <= slot_reg;
                        end
                    end else if (tick_last) begin
                        tick <= '0;
                        if (slot_last) begin
                            wr_en    <= 1'b1;
                            wr_addr  <= measure;
                            wr_data  <= word_next;
                            slot_reg <= '0;
                            slot     <= '0;
                            if (!meas_last) measure <= measure + MA'(1);
                        end else begin
                            slot_reg <= word_next;
                            slot     <= slot + SA'(1);
                        end
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_we    = wr_en || (state == S_CLEAR && record_in);
    assign mem_addr  = (state == S_CLEAR) ? clr_addr : wr_addr;
    assign mem_wdata = (state == S_CLEAR) ? '0 : wr_data;

    always_ff @(posedge pixel_clk_in) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    // read-first: a same-edge write is seen on the following read
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in)                     rd_data_out <= '0;
        else if (32'(rd_addr_in) < MEASURES) rd_data_out <= mem[rd_addr_in];
        else                               rd_data_out <= '0;
    end

endmodule

// File: tb/tb_note_grid_recorder.sv
// Self-checking bench for note_grid_recorder: slot-timing model derived from tempo arithmetic,
// measure-memory scoreboard, randomized notes/tempos. Honors COUNT_IN_EN when defined.
module tb_note_grid_recorder;

    localparam int NW   = 6;
    localparam int SPM  = 8;
    localparam int SPB  = 2;
    localparam int MEAS = 20;
    localparam int TW   = 26;
    localparam int MET  = 200000;
    localparam int MA   = $clog2(MEAS);
    localparam int SA   = $clog2(SPM);
    localparam int WW   = NW * SPM;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          record_in;
    logic [TW-1:0] ticks_per_slot_in;
    logic [NW-1:0] note_in;
    logic [MA-1:0] rd_addr_in;
    logic [WW-1:0] rd_data_out;
    logic          metronome_out;
    logic          recording_out;
    logic          done_out;
    logic [MA-1:0] measure_idx_out;
    logic [SA-1:0] slot_idx_out;

    int checks   = 0;
    int failures = 0;

    logic [WW-1:0] model_mem [MEAS];
    logic [NW-1:0] slot_notes [$];

    note_grid_recorder dut (
        .pixel_clk_in     (clk),
        .rst_n_in         (rst_n),
        .record_in        (record_in),
        .ticks_per_slot_in(ticks_per_slot_in),
        .note_in          (note_in),
        .rd_addr_in       (rd_addr_in),
        .rd_data_out      (rd_data_out),
        .metronome_out    (metronome_out),
        .recording_out    (recording_out),
        .done_out         (done_out),
        .measure_idx_out  (measure_idx_out),
        .slot_idx_out     (slot_idx_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // cycles from the record_in rise edge until RECORD begins
    function automatic int offset_for(input int eff);
`ifdef COUNT_IN_EN
        return MEAS + SPM * eff;
`else
        return MEAS;
`endif
    endfunction

    // mode 0: random notes each cycle, 1: note = slot number + 1, 2: constant 6'h21
    task automatic run_session(input int tps_req, input int nslots, input int mode);
        int eff, off, last;
        logic [NW-1:0] v;
        eff  = (tps_req == 0) ? 1 : tps_req;
        off  = offset_for(eff);
        last = off + nslots * eff;
        slot_notes.delete();
        ticks_per_slot_in = TW'(tps_req);
        record_in = 1'b1;
        for (int c = 0; c <= last; c++) begin
            if (c > 0) ticks_per_slot_in = TW'($urandom);
            if (mode == 2)      v = 6'h21;
            else if (mode == 1) v = (c > off) ? NW'((c - off - 1) / eff + 1) : '0;
            else                v = NW'($urandom);
            note_in = v;
            if (c > off && ((c - off) % eff) == 0) slot_notes.push_back(v);
            @(negedge clk);
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < MEAS; i++) model_mem[i] = '0;
        for (int g = 0; g < slot_notes.size(); g++)
            model_mem[g / SPM][(g % SPM) * NW +: NW] = slot_notes[g];
    endtask

    task automatic read_word(input int addr, output logic [WW-1:0] w);
        rd_addr_in = MA'(addr);
        @(negedge clk);
        w = rd_data_out;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        record_in = 1'b0;
        ticks_per_slot_in = '0;
        note_in = '0;
        rd_addr_in = '0;
        repeat (3) @(negedge clk);
        checks += 6;
        if (rd_data_out !== '0)     begin failures++; $display("FAIL reset_rd_data got=%0h exp=0", rd_data_out); end
        if (metronome_out !== 1'b0) begin failures++; $display("FAIL reset_metronome got=%0b exp=0", metronome_out); end
        if (recording_out !== 1'b0) begin failures++; $display("FAIL reset_recording got=%0b exp=0", recording_out); end
        if (done_out !== 1'b0)      begin failures++; $display("FAIL reset_done got=%0b exp=0", done_out); end
        if (measure_idx_out !== '0) begin failures++; $display("FAIL reset_measure got=%0d exp=0", measure_idx_out); end
        if (slot_idx_out !== '0)    begin failures++; $display("FAIL reset_slot got=%0d exp=0", slot_idx_out); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_constant();
        logic [WW-1:0] exp_w, w;
        exp_w = '0;
        for (int k = 0; k < SPM; k++) exp_w[k * NW +: NW] = 6'h21;
        run_session(4, 8, 2);
        record_in = 1'b0;
        repeat (2) @(negedge clk);
        checks += 3;
        if (recording_out !== 1'b0) begin failures++; $display("FAIL const_idle_recording got=%0b exp=0", recording_out); end
        read_word(0, w);
        if (w !== exp_w) begin failures++; $display("FAIL const_word0 got=%0h exp=%0h", w, exp_w); end
        read_word(1, w);
        if (w !== '0) begin failures++; $display("FAIL const_word1 got=%0h exp=0", w); end
    endtask

    task automatic test_partial();
        logic [WW-1:0] exp0, exp1, w;
        exp0 = '0;
        exp1 = '0;
        for (int k = 0; k < SPM; k++) exp0[k * NW +: NW] = NW'(k + 1);
        for (int k = 0; k < 3; k++)   exp1[k * NW +: NW] = NW'(k + 9);
        rd_addr_in = MA'(1);
        run_session(3, 11, 1);
        checks += 6;
        if (slot_idx_out !== SA'(3))    begin failures++; $display("FAIL partial_slot got=%0d exp=3", slot_idx_out); end
        if (measure_idx_out !== MA'(1)) begin failures++; $display("FAIL partial_measure got=%0d exp=1", measure_idx_out); end
        record_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (rd_data_out !== '0) begin failures++; $display("FAIL read_first_old got=%0h exp=0", rd_data_out); end
        @(negedge clk);
        if (rd_data_out !== exp1) begin failures++; $display("FAIL partial_word1 got=%0h exp=%0h", rd_data_out, exp1); end
        if (recording_out !== 1'b0) begin failures++; $display("FAIL partial_idle got=%0b exp=0", recording_out); end
        read_word(0, w);
        if (w !== exp0) begin failures++; $display("FAIL partial_word0 got=%0h exp=%0h", w, exp0); end
    endtask

    task automatic test_random();
        logic [WW-1:0] w;
        int t, n;
        for (int it = 0; it < 3; it++) begin
            t = $urandom_range(1, 4);
            n = $urandom_range(1, 40);
            run_session(t, n, 0);
            checks += 2;
            if (slot_idx_out !== SA'(n % SPM))
                begin failures++; $display("FAIL rand_slot it=%0d got=%0d exp=%0d", it, slot_idx_out, n % SPM); end
            if (measure_idx_out !== MA'(n / SPM))
                begin failures++; $display("FAIL rand_measure it=%0d got=%0d exp=%0d", it, measure_idx_out, n / SPM); end
            record_in = 1'b0;
            repeat (3) @(negedge clk);
            model_update();
            for (int a = 0; a < MEAS; a++) begin
                read_word(a, w);
                checks++;
                if (w !== model_mem[a])
                    begin failures++; $display("FAIL rand_word it=%0d addr=%0d got=%0h exp=%0h", it, a, w, model_mem[a]); end
            end
        end
    endtask

    task automatic test_tps_zero();
        logic [WW-1:0] w;
        run_session(0, SPM * MEAS, 0);
        checks += 3;
        if (done_out !== 1'b1)      begin failures++; $display("FAIL tps0_done got=%0b exp=1", done_out); end
        if (recording_out !== 1'b0) begin failures++; $display("FAIL tps0_recording got=%0b exp=0", recording_out); end
        record_in = 1'b0;
        @(negedge clk);
        if (done_out !== 1'b0) begin failures++; $display("FAIL tps0_idle_done got=%0b exp=0", done_out); end
        repeat (2) @(negedge clk);
        model_update();
        for (int a = 0; a < MEAS; a++) begin
            read_word(a, w);
            checks++;
            if (w !== model_mem[a])
                begin failures++; $display("FAIL tps0_word addr=%0d got=%0h exp=%0h", a, w, model_mem[a]); end
        end
    endtask

    task automatic test_metronome();
        int total, j, tk, sl, met_err, first_bad, highs, exp_highs;
        bit exp_m;
        total = offset_for(10) + SPM * MEAS * 10;
        met_err = 0;
        first_bad = -1;
        highs = 0;
        exp_highs = 0;
        checks++;
        if (metronome_out !== 1'b0) begin failures++; $display("FAIL met_idle got=%0b exp=0", metronome_out); end
        ticks_per_slot_in = TW'(10);
        note_in = '0;
        record_in = 1'b1;
        for (int c = 0; c < total + 4; c++) begin
            @(negedge clk);
            if (c < MEAS || c >= total) exp_m = 1'b0;
            else begin
                j  = c - MEAS;
                tk = j % 10;
                sl = (j / 10) % SPM;
                exp_m = ((sl % SPB) == 0) && (tk < ((MET < 10) ? MET : 10));
            end
            if (exp_m) exp_highs++;
            if (metronome_out === 1'b1) highs++;
            if (metronome_out !== exp_m) begin
                met_err++;
                if (first_bad < 0) first_bad = c;
            end
        end
        checks += 3;
        if (met_err !== 0)
            begin failures++; $display("FAIL met_pattern bad_cycles=%0d first_at=%0d exp_bad=0", met_err, first_bad); end
        if (highs !== exp_highs) begin failures++; $display("FAIL met_high_count got=%0d exp=%0d", highs, exp_highs); end
        if (done_out !== 1'b1) begin failures++; $display("FAIL met_done got=%0b exp=1", done_out); end
        record_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_record();
        logic [WW-1:0] w;
        int off;
        rd_addr_in = '0;
        run_session($urandom_range(1, 3), $urandom_range(2, 20), 0);
        #3 rst_n = 1'b0;
        #1;
        checks += 6;
        if (recording_out !== 1'b0) begin failures++; $display("FAIL midrst_recording got=%0b exp=0", recording_out); end
        if (slot_idx_out !== '0)    begin failures++; $display("FAIL midrst_slot got=%0d exp=0", slot_idx_out); end
        if (measure_idx_out !== '0) begin failures++; $display("FAIL midrst_measure got=%0d exp=0", measure_idx_out); end
        if (metronome_out !== 1'b0) begin failures++; $display("FAIL midrst_metronome got=%0b exp=0", metronome_out); end
        if (done_out !== 1'b0)      begin failures++; $display("FAIL midrst_done got=%0b exp=0", done_out); end
        if (rd_data_out !== '0)     begin failures++; $display("FAIL midrst_rd_data got=%0h exp=0", rd_data_out); end
        record_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        off = offset_for(2);
        ticks_per_slot_in = TW'(2);
        record_in = 1'b1;
        repeat (off) @(negedge clk);
        checks += 3;
        if (recording_out !== 1'b0) begin failures++; $display("FAIL restart_clear got=%0b exp=0", recording_out); end
        @(negedge clk);
        if (recording_out !== 1'b1) begin failures++; $display("FAIL restart_record got=%0b exp=1", recording_out); end
        record_in = 1'b0;
        repeat (3) @(negedge clk);
        read_word(0, w);
        if (w !== '0) begin failures++; $display("FAIL restart_word0 got=%0h exp=0", w); end
    endtask

`ifdef COUNT_IN_EN
    task automatic test_count_in();
        int rec_err, met_err, j;
        bit exp_m;
        rec_err = 0;
        met_err = 0;
        ticks_per_slot_in = TW'(5);
        note_in = '0;
        record_in = 1'b1;
        for (int c = 0; c < MEAS + SPM * 5; c++) begin
            @(negedge clk);
            j = c - MEAS;
            exp_m = (c >= MEAS) && (((j / 5) % SPM) % SPB == 0);
            if (recording_out !== 1'b0) rec_err++;
            if (metronome_out !== exp_m) met_err++;
        end
        checks += 4;
        if (rec_err !== 0) begin failures++; $display("FAIL countin_recording bad_cycles=%0d exp=0", rec_err); end
        if (met_err !== 0) begin failures++; $display("FAIL countin_metronome bad_cycles=%0d exp=0", met_err); end
        repeat (5) @(negedge clk);
        if (slot_idx_out !== '0 || recording_out !== 1'b1)
            begin failures++; $display("FAIL countin_pre_sample slot=%0d rec=%0b exp slot=0 rec=1", slot_idx_out, recording_out); end
        @(negedge clk);
        if (slot_idx_out !== SA'(1)) begin failures++; $display("FAIL countin_first_sample got=%0d exp=1", slot_idx_out); end
        record_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_constant();
        test_partial();
        test_random();
        test_tps_zero();
        test_metronome();
        test_reset_mid_record();
`ifdef COUNT_IN_EN
        test_count_in();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/note_grid_recorder.md
Name: note_grid_recorder

Overview:
- Parametrised successor to the fixed 8-slot, 20-measure note capture path feeding the staff renderer.
- Samples the pitch detector's note code once per rhythmic slot at a run-time programmable tempo.
- Packs each measure's slots into one word and writes it to an internal dual-port measure memory.
- Exposes a registered read port for the sprite/renderer side, plus metronome and progress status.

Parameters:
- NOTE_W, 6, width of one note code; 0 means rest.
- SLOTS_PER_MEASURE, 8, slots per measure; must be ≥2.
- SLOTS_PER_BEAT, 2, slots per metronome beat.
- MEASURES, 20, measure memory depth.
- TICK_W, 26, width of the tempo tick counter.
- MET_PULSE, 200000, metronome high time in clocks.

Ports:
- pixel_clk_in  in  1  sole clock.
- rst_n_in  in  1  asynchronous, active-low reset.
- record_in  in  1  level; high = record session requested.
- ticks_per_slot_in  in  TICK_W  clocks per slot; latched at session start.
- note_in  in  NOTE_W  current detected note code.
- rd_addr_in  in  $clog2(MEASURES)  renderer read address.
- rd_data_out  out  NOTE_W*SLOTS_PER_MEASURE  measure word. Slot k is at bits [k*NOTE_W +: NOTE_W].
- metronome_out  out  1  click pulse.
- recording_out  out  1  high in RECORD state.
- done_out  out  1  high in DONE state.
- measure_idx_out  out  $clog2(MEASURES)  current write measure.
- slot_idx_out  out  $clog2(SLOTS_PER_MEASURE)  current slot.

Behaviour:
- Reset: async assert on rst_n_in low; all outputs 0; state IDLE; counters 0; memory contents are not reset.
- States and transitions:
  - IDLE: record_in rising (registered compare) -> CLEAR. Latch tps = max(ticks_per_slot_in, 1).
  - CLEAR: write 0 to address 0..MEASURES-1, one address per cycle (MEASURES cycles) -> RECORD. Tick, slot and measure counters are zeroed on entry to RECORD.
  - RECORD: tick counts 0..tps-1.
    - At tick==tps-1: note_in is stored into slot register slot_idx; slot increments; tick returns to 0.
    - When the stored slot is SLOTS_PER_MEASURE-1: the packed word (including this cycle's note) is written to measure_idx the next cycle. The slot register clears, slot wraps to 0, and measure increments.
    - After writing measure MEASURES-1 -> DONE.
  - DONE: hold; record_in low -> IDLE.
- record_in falling in RECORD:
  - If slot_idx≠0, the partial measure is flushed in one write cycle; unsampled slots are 0 (rest).
  - Then -> IDLE.
  - Falling in CLEAR aborts to IDLE immediately; memory is left partially cleared.
- Simultaneous flush write and renderer read to the same address: read-first, so the old word is returned.
- Read port: rd_data_out is registered with 1-cycle latency and is valid in every state.
- metronome_out:
  - Asserted during RECORD for tick < min(MET_PULSE, tps) when slot_idx % SLOTS_PER_BEAT == 0.
  - 0 in all other states.
- ticks_per_slot_in changes mid-session are ignored until the next session.
- Tick counter must not overflow. Requirement: tps ≤ 2^TICK_W-1.

Optional Feature:
- Macro: COUNT_IN_EN.
- When defined:
  - A COUNT_IN state is inserted between CLEAR and RECORD, lasting exactly SLOTS_PER_MEASURE*tps clocks.
  - Metronome runs with the same rule as RECORD; no notes are sampled or written; recording_out stays 0.
  - record_in low during COUNT_IN -> IDLE.
- When undefined: CLEAR goes directly to RECORD; the COUNT_IN state and its logic are absent.

Test Plan:
- Reset mid-RECORD (rst_n_in low for 3 cycles at arbitrary phase) -> all outputs 0 asynchronously; IDLE; next record_in rise restarts with CLEAR.
- tps=4, note_in=6'h21 constant, record 1 measure then drop record_in -> address 0 reads 0x21 in all 8 slots one cycle after rd_addr_in=0; address 1 reads 0.
- tps=3, note_in steps 1,2,...,8 each slot, then record_in low after 3 slots of measure 1 -> word0 = slots 1..8; word1 = slots 9,10,11 with slots 3..7 = 0.
- ticks_per_slot_in=0 -> treated as 1; one slot per clock; 20 measures fill in 160 RECORD clocks; done_out=1; dropping record_in -> IDLE.
- tps=10, MET_PULSE=200000 -> metronome_out high for 10 clocks on even slots, low on odd slots, low in IDLE/CLEAR/DONE.
- COUNT_IN_EN, tps=5 -> 40 metronome-ticking clocks with recording_out=0 and no writes, then recording_out=1 and first sample on tick 4.
